// File: rtl/uart_word_serializer.sv
// Word FIFO plus byte framer that feeds a UART transmitter, MSB byte first,
// over the start/busy handshake of async_transmitter.
`timescale 1ns/1ps
module uart_word_serializer #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  output logic                          in_ready,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);

  localparam int unsigned WordW = 8 * WORD_BYTES;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdxW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CntW-1:0] CountFull = CntW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(WORD_BYTES - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitFree = 2'd1;
  localparam logic [1:0] StStart    = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [WordW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [WordW-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             push, pop;

  // Full FIFO stays closed even if a pop happens the same cycle.
  assign in_ready   = (count_q < CountFull);
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;
  assign idle       = (count_q == '0) && (state_q == StIdle);
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = StWaitFree;
        end
      end
      StWaitFree: begin
        // A busy left over from another requester must clear before we start.
        if (!tx_busy) begin
          tx_data_d  = shift_q[WordW-1 -: 8];
          tx_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = StWaitDone;
        end
      end
      default: begin
        if (!tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + IdxW'(1);
            state_d = StWaitFree;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule
